debounce_multi: RTL
===================

// Module: debounce_multi
// PURPOSE
//  NUM_CH-channel button/switch debouncer with a parametrised settle time and a
//  parametrised synchroniser depth. It debounces both press and release, where
//  a plain rising-edge-triggered timer only handles press. Sits between raw
//  board pins and user logic; replaces single-channel debouncers in top levels.
// PARAMETERS
//  NUM_CH       4         number of independent channels (>=1)
//  CLK_FREQ     50000000  clk frequency in Hz
//  DEBOUNCE_MS  10        required stable time in ms (>=1)
//  SYNC_STAGES  2         flops per channel in the input synchroniser (>=2)
//  Derived: CNT_MAX = (CLK_FREQ/1000)*DEBOUNCE_MS; must be >=1 (elaboration
//  $error otherwise). CNT_W = $clog2(CNT_MAX+1).
// PORTS
//  clk         in   1       single clock; all logic in this domain
//  rst         in   1       asynchronous, active-high reset
//  db_in       in   NUM_CH  raw asynchronous inputs, active high
//  db_out      out  NUM_CH  debounced level per channel
//  press_stb   out  NUM_CH  1-cycle pulse on debounced 0->1 (DEBOUNCE_STROBE_EN only)
//  release_stb out  NUM_CH  1-cycle pulse on debounced 1->0 (DEBOUNCE_STROBE_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): all synchroniser flops,
//    counters, db_out and strobes go to 0 immediately.
//  - Per channel, fully independent: db_in[i] passes through a SYNC_STAGES-deep
//    flop chain; its last stage is s[i].
//  - Per channel, two states: STABLE (s[i]==db_out[i], cnt=0) and
//    PENDING (s[i]!=db_out[i]).
//  - On each edge with s[i]!=db_out[i]:
//      if cnt==CNT_MAX-1: db_out[i] flips and cnt returns to 0;
//      else cnt increments.
//  - On any edge with s[i]==db_out[i], cnt clears to 0. A glitch shorter than
//    CNT_MAX cycles therefore never reaches db_out.
//  - Latency: an ideal step on db_in (set up before edge 1) appears on db_out
//    after edge SYNC_STAGES+CNT_MAX.
//  - Counter width is CNT_W. The counter never exceeds CNT_MAX-1 and never
//    wraps.
//  - Press and release are symmetric; both directions need CNT_MAX stable
//    cycles.
//  - Simultaneous changes on several channels are handled in parallel, with no
//    arbitration or interaction between channels.
//  - Reset mid-count discards the partial count. After reset, a held-high input
//    needs the full SYNC_STAGES+CNT_MAX to assert.
// CONFIGURATION
//  DEBOUNCE_STROBE_EN defined:
//    press_stb[i] / release_stb[i] are registered and high for exactly one clk
//    cycle: the cycle in which db_out[i] has just become 1 / 0, coincident with
//    the new db_out value.
//    Each press emits one press pulse and each release one release pulse, never
//    both in one cycle.
//  DEBOUNCE_STROBE_EN not defined:
//    press_stb and release_stb ports are absent and no edge-detect logic is
//    built.
// TESTING (NUM_CH=4, CLK_FREQ=1000, DEBOUNCE_MS=4 -> CNT_MAX=4, SYNC_STAGES=2)
//  - Clean press: db_in[0] 0->1 before edge 1 and held -> db_out[0]=1 after
//    edge 6, not after edge 5. With DEBOUNCE_STROBE_EN, press_stb[0]=1 only
//    during cycle 6.
//  - Bounce and glitches: db_in[1] toggles every 2 cycles for 20 cycles, then
//    stays 0 -> db_out[1] stays 0 throughout.
//    A 3-cycle high pulse leaves db_out[1]=0. A 4-cycle high pulse sets
//    db_out[1]=1.
//  - Release: db_out[2]=1 steady, db_in[2] 1->0 with a 2-cycle high bounce at
//    cycle 3 -> counter restarts; db_out[2]=0 exactly 6 edges after the last
//    bounce ends. release_stb[2] pulses once.
//  - Independence: db_in[3:0]=4'b1010 applied in the same cycle -> db_out
//    becomes 4'b1010 on the same edge (edge 6). Other channels are unaffected by
//    bouncing on channel 0.
//  - Reset mid-operation: assert rst for 1 cycle after edge 4 of a press ->
//    db_out and strobes are 0 immediately. With db_in held high, db_out=1
//    exactly 6 edges after rst deasserts.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: NUM_CH independent press/release debouncers behind a SYNC_STAGES-deep synchroniser.
// Define DEBOUNCE_STROBE_EN to add registered press_stb / release_stb edge pulses.
module debounce_multi #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ    = 50000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] db_in,
  output logic [NUM_CH-1:0] db_out
`ifdef DEBOUNCE_STROBE_EN
  ,
  output logic [NUM_CH-1:0] press_stb,
  output logic [NUM_CH-1:0] release_stb
`endif
);

  localparam int CNT_MAX = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  if (CNT_MAX < 1) begin : g_bad_cnt
    $error("debounce_multi: CNT_MAX = (CLK_FREQ/1000)*DEBOUNCE_MS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("debounce_multi: NUM_CH must be >= 1");
  end

  // Synchroniser: stage 0 samples the raw pins, the last stage feeds the debouncers
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_p0;
  logic [NUM_CH-1:0]                  s_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], db_in};
    end
  end

  assign s_p1 = sync_p0[SYNC_STAGES-1];

  // Per-channel stable-time counter and debounced level
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_p1;
    logic             out_p2;
    logic             differ_p1;
    logic             settle_p1;

    assign differ_p1 = s_p1[i] ^ out_p2;
    assign settle_p1 = differ_p1 && (cnt_p1 == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_p1 <= '0;
        out_p2 <= 1'b0;
      end else if (!differ_p1) begin
        cnt_p1 <= '0;
      end else if (settle_p1) begin
        cnt_p1 <= '0;
        out_p2 <= ~out_p2;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end

    assign db_out[i] = out_p2;

`ifdef DEBOUNCE_STROBE_EN
    // Strobes register alongside the flip so they coincide with the new level
    logic press_p2;
    logic release_p2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        press_p2   <= 1'b0;
        release_p2 <= 1'b0;
      end else begin
        press_p2   <= settle_p1 & s_p1[i];
        release_p2 <= settle_p1 & ~s_p1[i];
      end
    end

    assign press_stb[i]   = press_p2;
    assign release_stb[i] = release_p2;
`endif
  end

endmodule
